// File: rtl/imem_boot_loader.sv
// Boot loader: streams length, payload and XOR checksum into the byte-wide
// instruction memory, and releases the core only after a clean load.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   start         re-arm pulse from DONE or ERROR
//   in_valid      stream byte present on in_data
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle
//   mem_we        memory write strobe
//   mem_addr      memory byte address
//   mem_wdata     memory write byte
//   cpu_run       image valid, core may run
//   busy          set after length byte until checksum byte
//   err_code      0 none, 1 bad length, 2 checksum mismatch
module imem_boot_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          cpu_run,
    output logic          busy,
    output logic [1:0]    err_code
);

    typedef enum logic [2:0] {
        S_LEN,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    csum_q, csum_d;
    logic          we_d;
    logic [AW-1:0] addr_d;
    logic [7:0]    wdata_d;
    logic          run_d;
    logic          busy_d;
    logic [1:0]    err_d;
    logic          acc;

    assign in_ready = (state == S_LEN)
                    | (state == S_LOAD)
                    | (state == S_CHECK);
    assign acc = in_valid & in_ready;

    always_comb begin
        state_d = state;
        len_d   = len_q;
        count_d = count_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        run_d   = cpu_run;
        busy_d  = busy;
        err_d   = err_code;
        unique case (state)
            S_LEN: begin
                if (acc) begin
                    if (in_data == 8'd0 || in_data > 8'(DEPTH)) begin
                        err_d   = 2'd1;
                        state_d = S_ERROR;
                    end else begin
                        len_d   = (AW+1)'(in_data);
                        count_d = '0;
                        csum_d  = 8'd0;
                        busy_d  = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (acc) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[AW-1:0];
                    wdata_d = in_data;
                    csum_d  = csum_q ^ in_data;
                    count_d = count_q + (AW+1)'(1);
                    if (count_q == len_q - (AW+1)'(1))
                        state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (acc) begin
                    busy_d = 1'b0;
                    if (in_data == csum_q) begin
                        run_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 2'd2;
                        state_d = S_ERROR;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    run_d   = 1'b0;
                    err_d   = 2'd0;
                    count_d = '0;
                    csum_d  = 8'd0;
                    state_d = S_LEN;
                end
            end
            default: state_d = S_LEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_LEN;
            len_q     <= '0;
            count_q   <= '0;
            csum_q    <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            cpu_run   <= 1'b0;
            busy      <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state     <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            csum_q    <= csum_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            cpu_run   <= run_d;
            busy      <= busy_d;
            err_code  <= err_d;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: directed streams checked against a
// stream-position model every cycle, plus literal end-of-case checks.
module tb_imem_boot_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_run;
    logic          busy;
    logic [1:0]    err_code;

    imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .busy(busy), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: position of the accepted byte within the current stream
    // decides its role (0 = length, 1..L = payload, L+1 = checksum).
    int         m_idx, m_len;
    logic [7:0] m_csum;
    logic       m_run, m_busy, m_ready;
    logic [1:0] m_err;
    logic       e_we;
    int         e_addr;
    logic [7:0] e_data;
    bit         armed = 0;

    task automatic model_step();
        e_we = 1'b0;
        if (reset) begin
            m_idx = 0; m_len = 0; m_csum = 8'd0;
            m_run = 0; m_busy = 0; m_ready = 1; m_err = 2'd0;
        end else if (!m_ready) begin
            if (start) begin
                m_ready = 1; m_run = 0; m_err = 2'd0; m_idx = 0;
            end
        end else if (in_valid) begin
            if (m_idx == 0) begin
                if (in_data == 0 || int'(in_data) > DEPTH) begin
                    m_err = 2'd1; m_ready = 0;
                end else begin
                    m_len = int'(in_data); m_csum = 8'd0;
                    m_busy = 1; m_idx = 1;
                end
            end else if (m_idx <= m_len) begin
                e_we = 1'b1; e_addr = m_idx - 1; e_data = in_data;
                m_csum = m_csum ^ in_data; m_idx++;
            end else begin
                if (in_data == m_csum) m_run = 1;
                else m_err = 2'd2;
                m_busy = 0; m_ready = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        armed = 1;
    end

    logic [7:0] dmem [DEPTH];
    int         dwr = 0;

    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            if (e_we) begin
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(e_data));
            end
            chk("cpu_run", 32'(cpu_run), 32'(m_run));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("err_code", 32'(err_code), 32'(m_err));
        end
        if (mem_we === 1'b1) begin
            dmem[mem_addr] = mem_wdata;
            dwr++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit gaps);
        foreach (s[i]) begin
            if (!m_ready) break;
            if (gaps) begin
                for (int g = 0; g < 20 && $urandom_range(0, 9) >= 3; g++) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    cyc();
                end
            end
            in_valid = 1'b1;
            in_data  = s[i];
            cyc();
            in_valid = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_run"}, 32'(cpu_run), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err_code), 32'd0);
    endtask

    logic [7:0] s1[$];
    logic [7:0] sq[$];

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        cyc(); cyc();
        check_reset_vals("rst");
        reset = 1'b0;
        cyc();

        // Case 1: 20^08^00^05 = 2D
        s1 = '{8'h04, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        dwr = 0;
        send_stream(s1, 0);
        chk("c1_run", 32'(cpu_run), 32'd1);
        chk("c1_err", 32'(err_code), 32'd0);
        chk("c1_model_run", 32'(m_run), 32'd1);
        chk("c1_nwr", 32'(dwr), 32'd4);
        chk("c1_m0", 32'(dmem[0]), 32'h20);
        chk("c1_m1", 32'(dmem[1]), 32'h08);
        chk("c1_m2", 32'(dmem[2]), 32'h00);
        chk("c1_m3", 32'(dmem[3]), 32'h05);
        cyc();

        // Case 2: bad checksum
        pulse_start();
        dwr = 0;
        sq = '{8'h02, 8'hAA, 8'h55, 8'h00};
        send_stream(sq, 0);
        cyc();
        chk("c2_err", 32'(err_code), 32'd2);
        chk("c2_model_err", 32'(m_err), 32'd2);
        chk("c2_run", 32'(cpu_run), 32'd0);
        chk("c2_ready", 32'(in_ready), 32'd0);
        chk("c2_nwr", 32'(dwr), 32'd2);

        // Case 3: bad lengths
        pulse_start();
        chk("c3_clr", 32'(err_code), 32'd0);
        dwr = 0;
        sq = '{8'h00, 8'h11};
        send_stream(sq, 0);
        chk("c3_len0", 32'(err_code), 32'd1);
        pulse_start();
        chk("c3_clr2", 32'(err_code), 32'd0);
        sq = '{8'h21, 8'h11};
        send_stream(sq, 0);
        chk("c3_len33", 32'(err_code), 32'd1);
        chk("c3_nwr", 32'(dwr), 32'd0);
        pulse_start();
        chk("c3_ready", 32'(in_ready), 32'd1);
        chk("c3_clr3", 32'(err_code), 32'd0);

        // Case 4: full depth, bytes 00..1F, xor = 00
        dwr = 0;
        sq = {};
        sq.push_back(8'h20);
        for (int i = 0; i < DEPTH; i++) sq.push_back(8'(i));
        sq.push_back(8'h00);
        send_stream(sq, 0);
        chk("c4_run", 32'(cpu_run), 32'd1);
        chk("c4_nwr", 32'(dwr), 32'd32);
        chk("c4_last", 32'(dmem[31]), 32'h1F);
        chk("c4_first", 32'(dmem[0]), 32'h00);

        // Case 5: case 1 with gaps
        pulse_start();
        dwr = 0;
        send_stream(s1, 1);
        chk("c5_run", 32'(cpu_run), 32'd1);
        chk("c5_nwr", 32'(dwr), 32'd4);
        chk("c5_m3", 32'(dmem[3]), 32'h05);

        // Case 6: reset mid-load, ignored start during LOAD
        pulse_start();
        sq = '{8'h04, 8'h20, 8'h08};
        send_stream(sq, 0);
        pulse_start();
        chk("c6_busy", 32'(busy), 32'd1);
        chk("c6_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        cyc();
        check_reset_vals("c6rst");
        reset = 1'b0;
        dwr = 0;
        send_stream(s1, 0);
        chk("c6_run", 32'(cpu_run), 32'd1);
        chk("c6_nwr", 32'(dwr), 32'd4);
        chk("c6_m1", 32'(dmem[1]), 32'h08);

        cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
